// File: rtl/fpu_apu_dispatcher.sv
// Issue stage in front of the cv32e40p FP wrapper: holds one op across the APU
// req/gnt handshake and pairs in-order responses with queued destination tags.
module fpu_apu_dispatcher #(
    parameter int DEPTH = 4,
    parameter int RD_W  = 5
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         issue_valid_i,
    output logic                         issue_ready_o,
    input  logic [5:0]                   issue_op_i,
    input  logic [2:0]                   issue_rnd_i,
    input  logic [2:0][31:0]             issue_operands_i,
    input  logic [RD_W-1:0]              issue_rd_i,
    output logic                         apu_req_o,
    input  logic                         apu_gnt_i,
    output logic [2:0][31:0]             apu_operands_o,
    output logic [5:0]                   apu_op_o,
    output logic [10:0]                  apu_flags_o,
    input  logic                         apu_rvalid_i,
    input  logic [31:0]                  apu_rdata_i,
    input  logic [4:0]                   apu_rflags_i,
    output logic                         wb_valid_o,
    output logic [RD_W-1:0]              wb_rd_o,
    output logic [31:0]                  wb_data_o,
    output logic [4:0]                   fflags_o,
    input  logic                         fflags_clr_i,
    output logic [$clog2(DEPTH):0]       outstanding_o,
    output logic                         busy_o,
    output logic                         err_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic {IDLE, REQ} state_e;

    state_e state_q, state_d;
    logic   capture;

    logic [5:0]        hold_op_q;
    logic [2:0]        hold_rnd_q;
    logic [2:0][31:0]  hold_operands_q;
    logic [RD_W-1:0]   hold_rd_q;

    logic [RD_W-1:0]   fifo_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;

    logic granted, fifo_empty, bypass, push, pop, resp_ok, err_set;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        capture       = 1'b0;
        issue_ready_o = 1'b0;
        apu_req_o     = 1'b0;
        case (state_q)
            IDLE: begin
                issue_ready_o = (count_q < DEPTH_C);
                if (issue_valid_i && issue_ready_o) begin
                    capture = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                apu_req_o = 1'b1;
                if (apu_gnt_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Hold registers keep driving the wrapper after the grant, until the next capture.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_op_q       <= '0;
            hold_rnd_q      <= '0;
            hold_operands_q <= '0;
            hold_rd_q       <= '0;
        end else if (capture) begin
            hold_op_q       <= issue_op_i;
            hold_rnd_q      <= issue_rnd_i;
            hold_operands_q <= issue_operands_i;
            hold_rd_q       <= issue_rd_i;
        end
    end

    assign apu_op_o       = hold_op_q;
    assign apu_operands_o = hold_operands_q;
    assign apu_flags_o    = {2'b10, 6'b0, hold_rnd_q};

    // A zero-latency wrapper answers in the grant cycle; that response bypasses the tag FIFO.
    assign granted    = apu_req_o && apu_gnt_i;
    assign fifo_empty = (count_q == '0);
    assign bypass     = granted && apu_rvalid_i && fifo_empty;
    assign push       = granted && !bypass;
    assign pop        = apu_rvalid_i && !fifo_empty;
    assign resp_ok    = pop || bypass;
    assign err_set    = apu_rvalid_i && fifo_empty && !granted;

    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wr_ptr_q] <= hold_rd_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_q <= count_q + CNT_W'(1);
            else if (pop && !push) count_q <= count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wb_valid_o <= 1'b0;
            wb_rd_o    <= '0;
            wb_data_o  <= '0;
            fflags_o   <= '0;
            err_o      <= 1'b0;
        end else begin
            wb_valid_o <= resp_ok;
            if (resp_ok) begin
                wb_rd_o   <= bypass ? hold_rd_q : fifo_mem[rd_ptr_q];
                wb_data_o <= apu_rdata_i;
            end
            if (fflags_clr_i)  fflags_o <= resp_ok ? apu_rflags_i : 5'b0;
            else if (resp_ok)  fflags_o <= fflags_o | apu_rflags_i;
            if (err_set) err_o <= 1'b1;
        end
    end

    assign outstanding_o = count_q;
    assign busy_o        = (state_q == REQ) || !fifo_empty;

endmodule

// File: tb/tb_fpu_apu_dispatcher.sv
// Directed self-checking bench for fpu_apu_dispatcher (DEPTH=4, RD_W=5).
module tb_fpu_apu_dispatcher;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             issue_valid_i;
    logic             issue_ready_o;
    logic [5:0]       issue_op_i;
    logic [2:0]       issue_rnd_i;
    logic [2:0][31:0] issue_operands_i;
    logic [4:0]       issue_rd_i;
    logic             apu_req_o;
    logic             apu_gnt_i;
    logic [2:0][31:0] apu_operands_o;
    logic [5:0]       apu_op_o;
    logic [10:0]      apu_flags_o;
    logic             apu_rvalid_i;
    logic [31:0]      apu_rdata_i;
    logic [4:0]       apu_rflags_i;
    logic             wb_valid_o;
    logic [4:0]       wb_rd_o;
    logic [31:0]      wb_data_o;
    logic [4:0]       fflags_o;
    logic             fflags_clr_i;
    logic [2:0]       outstanding_o;
    logic             busy_o;
    logic             err_o;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    fpu_apu_dispatcher #(.DEPTH(4), .RD_W(5)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .issue_op_i(issue_op_i), .issue_rnd_i(issue_rnd_i),
        .issue_operands_i(issue_operands_i), .issue_rd_i(issue_rd_i),
        .apu_req_o(apu_req_o), .apu_gnt_i(apu_gnt_i),
        .apu_operands_o(apu_operands_o), .apu_op_o(apu_op_o), .apu_flags_o(apu_flags_o),
        .apu_rvalid_i(apu_rvalid_i), .apu_rdata_i(apu_rdata_i), .apu_rflags_i(apu_rflags_i),
        .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
        .fflags_o(fflags_o), .fflags_clr_i(fflags_clr_i),
        .outstanding_o(outstanding_o), .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        assert_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic applyStimulus(input logic [5:0] op, input logic [4:0] rd, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] c);
        issue_valid_i    = 1'b1;
        issue_op_i       = op;
        issue_rnd_i      = 3'd1;
        issue_rd_i       = rd;
        issue_operands_i = '{c, b, a};
        step();
        issue_valid_i    = 1'b0;
    endtask

    task automatic grantNow();
        apu_gnt_i = 1'b1;
        step();
        apu_gnt_i = 1'b0;
    endtask

    initial begin
        rst_ni = 1'b0;
        issue_valid_i = 0; issue_op_i = 0; issue_rnd_i = 0; issue_operands_i = '0; issue_rd_i = 0;
        apu_gnt_i = 0; apu_rvalid_i = 0; apu_rdata_i = 0; apu_rflags_i = 0; fflags_clr_i = 0;
        step();
        step();
        rst_ni = 1'b1;
        step();

        checkOutput("rst_wb_valid", wb_valid_o, 0);
        checkOutput("rst_req", apu_req_o, 0);
        checkOutput("rst_outstanding", outstanding_o, 0);
        checkOutput("rst_ready", issue_ready_o, 1);
        checkOutput("rst_busy", busy_o, 0);
        checkOutput("rst_fflags", fflags_o, 0);
        checkOutput("rst_err", err_o, 0);

        // Zero-latency wrapper: grant and response in the same cycle.
        applyStimulus(6'b000100, 5'd7, 32'h40800000, 32'h40800000, 32'h40800000);
        checkOutput("byp_req", apu_req_o, 1);
        checkOutput("byp_op", apu_op_o, 6'b000100);
        checkOutput("byp_flags", apu_flags_o, 11'b100_0000_0001);
        apu_gnt_i = 1; apu_rvalid_i = 1; apu_rdata_i = 32'h41000000; apu_rflags_i = 0;
        step();
        apu_gnt_i = 0; apu_rvalid_i = 0;
        checkOutput("byp_req_drop", apu_req_o, 0);
        checkOutput("byp_wb_valid", wb_valid_o, 1);
        checkOutput("byp_wb_rd", wb_rd_o, 7);
        checkOutput("byp_wb_data", wb_data_o, 32'h41000000);
        checkOutput("byp_outstanding", outstanding_o, 0);
        step();
        checkOutput("byp_wb_pulse", wb_valid_o, 0);

        // Grant withheld for three cycles.
        applyStimulus(6'h11, 5'd9, 32'h1, 32'h2, 32'h3);
        for (int i = 0; i < 4; i++) begin
            checkOutput("stall_req", apu_req_o, 1);
            checkOutput("stall_op", apu_op_o, 6'h11);
            checkOutput("stall_operands", apu_operands_o, {32'h3, 32'h2, 32'h1});
            checkOutput("stall_ready", issue_ready_o, 0);
            if (i < 3) step();
        end
        grantNow();
        checkOutput("stall_outstanding", outstanding_o, 1);
        checkOutput("stall_hold_after", apu_op_o, 6'h11);
        apu_rvalid_i = 1; apu_rdata_i = 32'hCAFE0009;
        step();
        apu_rvalid_i = 0;
        checkOutput("stall_wb_rd", wb_rd_o, 9);
        checkOutput("stall_wb_data", wb_data_o, 32'hCAFE0009);
        checkOutput("stall_drained", outstanding_o, 0);

        // Fill the tag FIFO, then drain in order.
        for (int r = 1; r <= 4; r++) begin
            applyStimulus(6'h2, 5'(r), 32'(r), 0, 0);
            grantNow();
        end
        checkOutput("full_outstanding", outstanding_o, 4);
        checkOutput("full_ready", issue_ready_o, 0);
        checkOutput("full_busy", busy_o, 1);
        for (int r = 1; r <= 4; r++) begin
            apu_rvalid_i = 1;
            apu_rdata_i  = 32'h100 + 32'(r);
            apu_rflags_i = (r == 1) ? 5'b00001 : (r == 2) ? 5'b10000 : 5'b0;
            step();
            checkOutput("drain_wb_valid", wb_valid_o, 1);
            checkOutput("drain_wb_rd", wb_rd_o, 5'(r));
            checkOutput("drain_wb_data", wb_data_o, 32'h100 + 32'(r));
        end
        apu_rvalid_i = 0; apu_rflags_i = 0;
        checkOutput("drain_outstanding", outstanding_o, 0);
        checkOutput("drain_ready", issue_ready_o, 1);
        checkOutput("drain_fflags", fflags_o, 5'b10001);

        // Clear together with a response keeps only the new flags.
        applyStimulus(6'h3, 5'd12, 0, 0, 0);
        grantNow();
        apu_rvalid_i = 1; apu_rflags_i = 5'b00100; fflags_clr_i = 1; apu_rdata_i = 32'h5;
        step();
        apu_rvalid_i = 0; apu_rflags_i = 0; fflags_clr_i = 0;
        checkOutput("clr_resp_fflags", fflags_o, 5'b00100);
        checkOutput("clr_resp_wb_rd", wb_rd_o, 12);

        // Orphan response: error, no writeback, flags untouched.
        step();
        apu_rvalid_i = 1; apu_rflags_i = 5'b11111; apu_rdata_i = 32'hDEAD;
        step();
        apu_rvalid_i = 0; apu_rflags_i = 0;
        checkOutput("orphan_err", err_o, 1);
        checkOutput("orphan_wb_valid", wb_valid_o, 0);
        checkOutput("orphan_fflags", fflags_o, 5'b00100);
        checkOutput("orphan_wb_data", wb_data_o, 32'h5);
        step(); step();
        checkOutput("orphan_err_sticky", err_o, 1);

        fflags_clr_i = 1;
        step();
        fflags_clr_i = 0;
        checkOutput("clr_alone", fflags_o, 0);

        // Asynchronous reset in REQ with two outstanding.
        applyStimulus(6'h4, 5'd20, 0, 0, 0);
        grantNow();
        applyStimulus(6'h4, 5'd21, 0, 0, 0);
        grantNow();
        applyStimulus(6'h4, 5'd22, 0, 0, 0);
        checkOutput("pre_rst_req", apu_req_o, 1);
        checkOutput("pre_rst_outstanding", outstanding_o, 2);
        #2;
        rst_ni = 1'b0;
        #1;
        checkOutput("arst_req", apu_req_o, 0);
        checkOutput("arst_outstanding", outstanding_o, 0);
        checkOutput("arst_busy", busy_o, 0);
        checkOutput("arst_err", err_o, 0);
        checkOutput("arst_op", apu_op_o, 0);
        step();
        rst_ni = 1'b1;
        step();
        checkOutput("post_rst_ready", issue_ready_o, 1);
        checkOutput("post_rst_wb_valid", wb_valid_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
